dostring_rx: RTL and testbench

DOSTRING_RX -- requirements
Module: dostring_rx

---
 rtl/dostring_rx.sv | 181 ++++++++++++++++++
 tb/tb_dostring_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dostring_rx.sv
// dostring_rx: receiver for an APA102-style LED strip stream (sck/mosi).
// Both strip inputs are synchronised to dostring_clk. Each decoded LED frame
// is presented with a one-cycle pixel_valid pulse. The end of a strip frame
// is signalled with frame_done, and a rejected word with header_err.
// Optional feature: define DOSTRING_RX_TIMEOUT_EN to add an idle timeout.
// With the timeout, the receiver realigns the bit counter and closes an open
// frame once TIMEOUT_CYCLES clocks pass with no sck edge.
// MAX_LEDS must be at least 2.
module dostring_rx #(
  parameter int MAX_LEDS       = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        dostring_clk,
  input  logic                        dostring_reset,
  input  logic                        sck,
  input  logic                        mosi,
  output logic                        pixel_valid,
  output logic [$clog2(MAX_LEDS)-1:0] pixel_index,
  output logic [4:0]                  brightness,
  output logic [7:0]                  blue,
  output logic [7:0]                  green,
  output logic [7:0]                  red,
  output logic                        frame_done,
  output logic                        header_err
);

  localparam int IW = $clog2(MAX_LEDS);
  // One extra count so the position can reach MAX_LEDS without wrapping.
  localparam int CW = $clog2(MAX_LEDS + 1);

  if (MAX_LEDS < 2) begin : g_bad_max_leds
    $error("dostring_rx: MAX_LEDS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dostring_rx: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {HUNT, PIXEL} state_t;

  state_t        r_state, w_state_nx;
  logic          r_sck_s1, r_sck_s2, r_sck_d;
  logic          r_mosi_s1, r_mosi_s2;
  // The 32nd bit is taken straight from the synchroniser, so 31 bits are enough.
  logic [30:0]   r_shift;
  logic [4:0]    r_bitcnt;
  logic [CW-1:0] r_count, w_count_nx;
  logic          w_edge, w_word_done;
  logic [31:0]   w_word;
  logic          w_pv, w_fd, w_he;

  assign w_edge      = r_sck_s2 & ~r_sck_d;
  assign w_word_done = w_edge && (r_bitcnt == 5'd31);
  assign w_word      = {r_shift, r_mosi_s2};

`ifdef DOSTRING_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle;
  logic          w_timeout;

  assign w_timeout = !w_edge && (r_idle == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: counts cycles since the last sck edge.
  always_ff @(posedge dostring_clk) begin
    if (dostring_reset || w_edge || w_timeout) r_idle <= '0;
    else                                       r_idle <= r_idle + 1'b1;
  end
`endif

  // Two-stage synchronisers plus the previous-sck register for edge detection.
  always_ff @(posedge dostring_clk) begin
    if (dostring_reset) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Shift register and bit counter, advanced on each detected sck rising edge.
  always_ff @(posedge dostring_clk) begin
    if (dostring_reset) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_edge) begin
      r_shift  <= {r_shift[29:0], r_mosi_s2};
      r_bitcnt <= r_bitcnt + 5'd1;
`ifdef DOSTRING_RX_TIMEOUT_EN
    end else if (w_timeout) begin
      r_bitcnt <= '0;
`endif
    end
  end

  // FSM state and LED position registers.
  always_ff @(posedge dostring_clk) begin
    if (dostring_reset) begin
      r_state <= HUNT;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
    end
  end

  // Next-state decode of each completed word.
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_pv       = 1'b0;
    w_fd       = 1'b0;
    w_he       = 1'b0;
    if (w_word_done) begin
      unique case (r_state)
        HUNT: begin
          if (w_word == '0) begin
            w_state_nx = PIXEL;
            w_count_nx = '0;
          end
        end
        PIXEL: begin
          if (w_word == '1) begin
            w_fd       = 1'b1;
            w_state_nx = HUNT;
          end else if (w_word == '0) begin
            w_count_nx = '0;
          end else if (w_word[31:29] == 3'b111) begin
            if (r_count == CW'(MAX_LEDS)) begin
              w_he = 1'b1;
            end else begin
              w_pv       = 1'b1;
              w_count_nx = r_count + 1'b1;
            end
          end else begin
            w_he       = 1'b1;
            w_state_nx = HUNT;
          end
        end
        default: w_state_nx = HUNT;
      endcase
    end
`ifdef DOSTRING_RX_TIMEOUT_EN
    if (w_timeout && r_state == PIXEL) begin
      w_fd       = 1'b1;
      w_state_nx = HUNT;
    end
`endif
  end

  // Registered outputs: pulses for one cycle; data fields hold until the next pixel.
  always_ff @(posedge dostring_clk) begin
    if (dostring_reset) begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      header_err  <= 1'b0;
      pixel_index <= '0;
      brightness  <= '0;
      blue        <= '0;
      green       <= '0;
      red         <= '0;
    end else begin
      pixel_valid <= w_pv;
      frame_done  <= w_fd;
      header_err  <= w_he;
      if (w_pv) begin
        pixel_index <= r_count[IW-1:0];
        brightness  <= w_word[28:24];
        blue        <= w_word[23:16];
        green       <= w_word[15:8];
        red         <= w_word[7:0];
      end
    end
  end

endmodule

// File: tb/tb_dostring_rx.sv
// Scoreboard testbench for dostring_rx (MAX_LEDS=2, TIMEOUT_CYCLES=64).
module tb_dostring_rx;

  logic       clk, rst, sck, mosi;
  logic       pixel_valid, frame_done, header_err;
  logic [0:0] pixel_index;
  logic [4:0] brightness;
  logic [7:0] blue, green, red;

  dostring_rx #(.MAX_LEDS(2), .TIMEOUT_CYCLES(64)) dut (
    .dostring_clk  (clk),
    .dostring_reset(rst),
    .sck           (sck),
    .mosi          (mosi),
    .pixel_valid   (pixel_valid),
    .pixel_index   (pixel_index),
    .brightness    (brightness),
    .blue          (blue),
    .green         (green),
    .red           (red),
    .frame_done    (frame_done),
    .header_err    (header_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 0 pixel, 1 frame_done, 2 header_err
    int idx;
    int b;
    int bl;
    int g;
    int r;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  fd_cyc   = -1;
  int  last_rise = 0;
  int  l_idx = 0, l_b = 0, l_bl = 0, l_g = 0, l_r = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int idx, input logic [31:0] w);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.b    = int'(w[28:24]);
    e.bl   = int'(w[23:16]);
    e.g    = int'(w[15:8]);
    e.r    = int'(w[7:0]);
    q.push_back(e);
  endtask

  // Monitor: pops the oldest expectation whenever the DUT pulses an event.
  always @(negedge clk) begin
    if (!rst && (pixel_valid || frame_done || header_err)) begin
      check("one_pulse", 32'(pixel_valid) + 32'(frame_done) + 32'(header_err), 32'd1);
      if (frame_done) fd_cyc = cyc;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got pv=%0b fd=%0b he=%0b required none (t=%0t)",
                 pixel_valid, frame_done, header_err, $time);
      end else begin
        ev_t e;
        int  k;
        e = q.pop_front();
        k = pixel_valid ? 0 : (frame_done ? 1 : 2);
        check("event_kind", 32'(k), 32'(e.kind));
        if (e.kind == 0) begin
          l_idx = e.idx; l_b = e.b; l_bl = e.bl; l_g = e.g; l_r = e.r;
        end
        check("pixel_index", 32'(pixel_index), 32'(l_idx));
        check("brightness",  32'(brightness),  32'(l_b));
        check("blue",        32'(blue),        32'(l_bl));
        check("green",       32'(green),       32'(l_g));
        check("red",         32'(red),         32'(l_r));
      end
    end
  end

  // Watchdog: bounds the whole run.
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    mosi = b;
    repeat (4) @(posedge clk);
    #1 sck = 1'b1;
    last_rise = cyc;
    repeat (4) @(posedge clk);
    #1 sck = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_frame_done",  32'(frame_done),  32'd0);
    check("rst_header_err",  32'(header_err),  32'd0);
    check("rst_pixel_index", 32'(pixel_index), 32'd0);
    check("rst_brightness",  32'(brightness),  32'd0);
    check("rst_blue",        32'(blue),        32'd0);
    check("rst_green",       32'(green),       32'd0);
    check("rst_red",         32'(red),         32'd0);
    l_idx = 0; l_b = 0; l_bl = 0; l_g = 0; l_r = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    sck  = 1'b0;
    mosi = 1'b0;
    rst  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Two LEDs then end of frame.
    send_word(32'h0);
    push(0, 0, 32'hFF102030);
    send_word(32'hFF102030);
    push(0, 1, 32'hE5AABBCC);
    send_word(32'hE5AABBCC);
    push(1, 0, 32'hFFFFFFFF);
    send_word(32'hFFFFFFFF);

    // Bad header returns to HUNT; the next LED word is ignored.
    send_word(32'h0);
    push(2, 0, 32'h0);
    send_word(32'h7F000000);
    send_word(32'hE1010101);

    // MAX_LEDS=2: third LED word rejected, still in PIXEL so all-ones ends the frame.
    send_word(32'h0);
    push(0, 0, 32'hE1112233);
    send_word(32'hE1112233);
    push(0, 1, 32'hE2445566);
    send_word(32'hE2445566);
    push(2, 0, 32'h0);
    send_word(32'hE3778899);
    push(1, 0, 32'h0);
    send_word(32'hFFFFFFFF);

    // A start word inside a frame restarts the index.
    send_word(32'h0);
    push(0, 0, 32'hE0000010);
    send_word(32'hE0000010);
    send_word(32'h0);
    push(0, 0, 32'hE7000020);
    send_word(32'hE7000020);
    push(1, 0, 32'h0);
    send_word(32'hFFFFFFFF);

    // Reset 17 bits into an LED word; decoding resumes only after a new start word.
    send_word(32'h0);
    push(0, 0, 32'hE3123456);
    send_word(32'hE3123456);
    send_bits(32'hE1FFFFFF, 17);
    do_reset();
    send_word(32'h0);
    push(0, 0, 32'hE0000001);
    send_word(32'hE0000001);
    push(1, 0, 32'h0);
    send_word(32'hFFFFFFFF);

    // Idle mid-word inside a frame.
    send_word(32'h0);
    push(0, 0, 32'hE0ABCDEF);
    send_word(32'hE0ABCDEF);
    send_bits(32'hFFFFFFFF, 10);
`ifdef DOSTRING_RX_TIMEOUT_EN
    push(1, 0, 32'h0);
    fd_cyc = -1;
    repeat (100) @(posedge clk);
    #1;
    check("timeout_delay_in_window",
          32'((fd_cyc - last_rise >= 60) && (fd_cyc - last_rise <= 75)), 32'd1);
    send_word(32'hE0000005);
`else
    repeat (100) @(posedge clk);
    #1;
`endif
    do_reset();

    repeat (100) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
